// File: rtl/mem_arbiter.sv
// N-channel arbiter onto one shared byte-write RAM port. Reads are credit-limited and
// their responses return strictly in order through a FIFO with per-channel flush.
module mem_arbiter #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NB_COL     = 4,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            req_valid,
    output logic [N_CH-1:0]            req_ready,
    input  logic [N_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_CH*NB_COL-1:0]     req_we,
    input  logic [N_CH*8*NB_COL-1:0]   req_wdata,
    input  logic [N_CH-1:0]            flush,
    output logic [N_CH-1:0]            rsp_valid,
    input  logic [N_CH-1:0]            rsp_ready,
    output logic [8*NB_COL-1:0]        rsp_data,
    output logic                       mem_en,
    output logic [NB_COL-1:0]          mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [8*NB_COL-1:0]        mem_din,
    input  logic [8*NB_COL-1:0]        mem_dout
);
    localparam int unsigned DW    = 8 * NB_COL;
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned IDX_W = $clog2(RSP_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Arbitration
    logic [N_CH-1:0] is_rd;
    logic [N_CH-1:0] elig;
    logic            credit_ok;
    logic            gnt_any;
    logic            gnt;
    logic            gnt_rd;
    logic [CH_W-1:0] gnt_idx;
    int unsigned     rr_idx;
    logic [CH_W-1:0] rr_ptr_d, rr_ptr_q;

    // Read pipe tracking the memory latency
    logic [RD_LATENCY-1:0]           pipe_vld_d, pipe_vld_q;
    logic [RD_LATENCY-1:0]           pipe_keep_d, pipe_keep_q;
    logic [RD_LATENCY-1:0][CH_W-1:0] pipe_ch_d, pipe_ch_q;
    logic                            exit_vld;
    logic                            exit_keep;
    logic [CH_W-1:0]                 exit_ch;
    logic [CNT_W-1:0]                inflight_cnt;

    // Response FIFO
    logic [RSP_DEPTH-1:0]           fifo_keep_d, fifo_keep_q;
    logic [RSP_DEPTH-1:0][CH_W-1:0] fifo_ch_d, fifo_ch_q;
    logic [DW-1:0]                  fifo_data_d [RSP_DEPTH];
    logic [DW-1:0]                  fifo_data_q [RSP_DEPTH];
    logic [PTR_W-1:0]               wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0]               rd_ptr_d, rd_ptr_q;
    logic [PTR_W-1:0]               fifo_count;
    logic [IDX_W-1:0]               wr_idx;
    logic [IDX_W-1:0]               head_idx;
    logic [CH_W-1:0]                head_ch;
    logic                           head_keep;
    logic                           empty;
    logic                           push;
    logic                           pop;

    always_comb begin
        inflight_cnt = '0;
        for (int s = 0; s < RD_LATENCY; s++) begin
            inflight_cnt = inflight_cnt + CNT_W'(pipe_vld_q[s]);
        end
        fifo_count = wr_ptr_q - rd_ptr_q;
        credit_ok  = (CNT_W'(fifo_count) + inflight_cnt) < CNT_W'(RSP_DEPTH);
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            is_rd[i] = ~|req_we[i*NB_COL +: NB_COL];
            elig[i]  = req_valid[i] & ~flush[i] & (~is_rd[i] | credit_ok);
        end
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        if (ARB_MODE == 0) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CH_W'(i);
                end
            end
        end else begin
            // Walk from the farthest candidate back to ptr+1 so the nearest eligible wins.
            for (int unsigned k = N_CH; k >= 1; k--) begin
                rr_idx = (32'(rr_ptr_q) + k) % N_CH;
                if (elig[rr_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CH_W'(rr_idx);
                end
            end
        end
        gnt      = gnt_any & ~rst;
        gnt_rd   = gnt & is_rd[gnt_idx];
        rr_ptr_d = gnt ? gnt_idx : rr_ptr_q;
    end

    always_comb begin
        req_ready = '0;
        mem_en    = gnt;
        mem_we    = '0;
        mem_addr  = '0;
        mem_din   = '0;
        if (gnt) begin
            req_ready[gnt_idx] = 1'b1;
            mem_we             = req_we[gnt_idx*NB_COL +: NB_COL];
            mem_addr           = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_din            = req_wdata[gnt_idx*DW +: DW];
        end
    end

    // Flush is applied to every stage while it shifts, including the exiting one.
    always_comb begin
        pipe_vld_d[0]  = gnt_rd;
        pipe_keep_d[0] = 1'b1;
        pipe_ch_d[0]   = gnt_idx;
        for (int s = 1; s < RD_LATENCY; s++) begin
            pipe_vld_d[s]  = pipe_vld_q[s-1];
            pipe_keep_d[s] = pipe_keep_q[s-1] & ~flush[pipe_ch_q[s-1]];
            pipe_ch_d[s]   = pipe_ch_q[s-1];
        end
        exit_vld  = pipe_vld_q[RD_LATENCY-1];
        exit_ch   = pipe_ch_q[RD_LATENCY-1];
        exit_keep = pipe_keep_q[RD_LATENCY-1] & ~flush[exit_ch];
    end

    always_comb begin
        wr_idx    = wr_ptr_q[IDX_W-1:0];
        head_idx  = rd_ptr_q[IDX_W-1:0];
        empty     = (wr_ptr_q == rd_ptr_q);
        head_ch   = fifo_ch_q[head_idx];
        head_keep = fifo_keep_q[head_idx] & ~flush[head_ch];
        push      = exit_vld;
        // Dropped heads drain on their own; live heads wait for their channel.
        pop       = ~empty & (~head_keep | rsp_ready[head_ch]);

        fifo_ch_d   = fifo_ch_q;
        fifo_data_d = fifo_data_q;
        for (int e = 0; e < RSP_DEPTH; e++) begin
            fifo_keep_d[e] = fifo_keep_q[e] & ~flush[fifo_ch_q[e]];
        end
        if (push) begin
            fifo_keep_d[wr_idx] = exit_keep;
            fifo_ch_d[wr_idx]   = exit_ch;
            fifo_data_d[wr_idx] = mem_dout;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            rsp_valid[i] = ~rst & ~empty & head_keep & (head_ch == CH_W'(i));
        end
        rsp_data = rst ? '0 : fifo_data_q[head_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= CH_W'(N_CH - 1);
            pipe_vld_q  <= '0;
            pipe_keep_q <= '0;
            pipe_ch_q   <= '0;
            fifo_keep_q <= '0;
            fifo_ch_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_keep_q <= pipe_keep_d;
            pipe_ch_q   <= pipe_ch_d;
            fifo_keep_q <= fifo_keep_d;
            fifo_ch_q   <= fifo_ch_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes instruction-fetch, load/store and future requestors onto one port of the shared byte-write RAM.
- Successor to the fixed pmem/dmem split in the core: adds a ready/valid request handshake, fixed-priority or round-robin arbitration, and a credit-limited in-order response FIFO with per-channel flush for mispredict recovery.

Parameters:
- N_CH, 2, number of requesting channels (1..8).
- ADDR_WIDTH, 32, word address width on both request and memory side.
- NB_COL, 4, byte-write columns; data width = 8*NB_COL.
- RD_LATENCY, 1, memory read latency in edges (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE).
- ARB_MODE, 0, 0 = fixed priority (ch0 highest), 1 = round robin.
- RSP_DEPTH, 4, response FIFO depth and read credit limit (power of 2, >= 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_CH  request valid per channel
- req_ready  out  N_CH  grant; handshake completes when valid & ready
- req_addr  in  N_CH*ADDR_WIDTH  per-channel word address; ch i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_we  in  N_CH*NB_COL  byte write enables; all zero = read
- req_wdata  in  N_CH*8*NB_COL  write data
- flush  in  N_CH  drop all pending read responses of the channel
- rsp_valid  out  N_CH  response available for the channel
- rsp_ready  in  N_CH  channel consumes the response
- rsp_data  out  8*NB_COL  read data of the FIFO head, shared by all channels
- mem_en  out  1  memory port enable
- mem_we  out  NB_COL  memory byte write enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  8*NB_COL  memory write data
- mem_dout  in  8*NB_COL  memory read data

Behaviour:
- Reset: FIFO empty, in-flight pipe cleared, RR pointer = N_CH-1 so ch0 wins first. While rst is high: req_ready = 0, mem_en = 0, mem_we = 0, rsp_valid = 0, rsp_data = 0.
- Eligibility: ch i is eligible if req_valid[i] & !flush[i]. Reads also need credit: fifo_count + inflight_reads < RSP_DEPTH. Writes need no credit.
- Arbitration: at most one grant per cycle, combinational from the current inputs and state.
  - Fixed mode: lowest eligible index wins.
  - RR mode: search starts at ptr+1, modulo N_CH. ptr <= granted index on a grant only.
- Memory drive, same cycle as the grant: mem_en = 1, mem_addr/mem_din/mem_we taken from the granted channel. With no grant, mem_en = 0 and mem_we = 0.
- Read tracking:
  - A granted read pushes {valid, ch} into an RD_LATENCY-deep shift pipe.
  - At pipe exit, mem_dout and ch are written into the FIFO at that edge.
  - rsp_valid is asserted on the following cycle, giving a minimum request-to-response latency of RD_LATENCY+1 cycles.
- Writes produce no response and never enter the pipe.
- Response delivery:
  - Strictly in order; head-of-line blocking across channels is accepted.
  - rsp_valid[i] = !empty & head.keep & head.ch == i; rsp_data = head.data.
  - Pop when rsp_ready[head.ch] is high.
  - A head entry with keep = 0 pops automatically without asserting rsp_valid.
- Flush[i] clears the keep bit of every FIFO entry and every pipe entry tagged i, in the same cycle. An entry exiting the pipe in the flush cycle is stored with keep = 0. Credits are returned only on pop, so dropped entries drain at one per cycle.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Full FIFO plus pop: new read credit becomes visible next cycle (credit uses registered counts).
  - A flush on the head channel while its rsp_ready is high: no pop with rsp_valid; the entry is dropped.
- Credit invariant: fifo_count + inflight_reads <= RSP_DEPTH at all times; overflow is impossible by construction. The bench asserts this.
- Pointer wrap: FIFO pointers are log2(RSP_DEPTH)+1 bits; full/empty is decided by comparing MSBs.
- Reset mid-operation: in-flight and queued responses are discarded; the memory write in progress at the reset edge is the memory's concern.

Test Plan:
- N_CH=2, RD_LATENCY=1, mem[0x10]=0xDEADBEEF; ch0 reads 0x10, rsp_ready=1 -> req_ready[0]=1 in the request cycle; rsp_valid[0]=1 with rsp_data=0xDEADBEEF exactly 2 cycles after the handshake, for 1 cycle.
- ARB_MODE=0, both channels issue back-to-back reads for 6 cycles -> ch0 granted 6/6 cycles, req_ready[1]=0 throughout; ch1 granted the cycle after ch0 drops req_valid.
- ARB_MODE=1, both channels issue continuous reads -> grant sequence 0,1,0,1; responses return with the same channel tags in order.
- rsp_ready[1]=0, ch1 issues 6 reads -> exactly 4 accepted, then req_ready[1]=0; a ch0 write of 0xA5 with mem_we=4'b0001 is still granted; raising rsp_ready[1] delivers 4 responses in order.
- ch1 has 2 reads queued behind a ch0 read; pulse flush[1] -> rsp_valid[1] never asserts; ch0 data delivered; FIFO empty 3 cycles later; full credit restored.
- 3 responses queued, rst pulsed mid-stream -> all outputs 0 while rst is high; after release, the first RR grant with both channels valid goes to ch0; no stale rsp_valid.
